// File: rtl/irq_request_unit.sv
// Debounced three-source interrupt request unit with fixed priority (2 > 1 > 0).
// Optional runtime source mask is built when IRQ_MASK_EN is defined; otherwise all sources are unmasked.
module irq_request_unit #(
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] btn_i,
   input  logic       ie_i,
   input  logic       ack_valid_i,
   input  logic [1:0] ack_id_i,
`ifdef IRQ_MASK_EN
   input  logic       mask_we_i,
   input  logic [2:0] mask_wdata_i,
`endif
   output logic       irq_valid_o,
   output logic [1:0] irq_id_o,
   output logic [2:0] irw_o,
   output logic [2:0] overrun_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       pending_q, pending_d;
   logic [2:0]       overrun_q, overrun_d;
   logic [2:0]       mask_q;
   logic [2:0]       accept, rise, ack_hit, active;

   always_comb begin
      stable_d  = stable_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      accept    = '0;
      rise      = '0;
      ack_hit   = '0;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               accept[i]   = 1'b1;
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         rise[i]    = accept[i] & sync2_q[i];
         ack_hit[i] = ack_valid_i && (ack_id_i == i[1:0]);
         // A fresh press on the same edge as its ack re-arms the request but wipes the overrun history.
         pending_d[i] = rise[i] | (pending_q[i] & ~ack_hit[i]);
         overrun_d[i] = ack_hit[i] ? 1'b0 : (overrun_q[i] | (rise[i] & pending_q[i]));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef IRQ_MASK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)          mask_q <= 3'b111;
      else if (mask_we_i) mask_q <= mask_wdata_i;
   end
`else
   assign mask_q = 3'b111;
`endif

   assign active      = pending_q & mask_q;
   assign irq_valid_o = ie_i & (|active);
   assign irw_o       = pending_q;
   assign overrun_o   = overrun_q;

   always_comb begin
      irq_id_o = 2'd0;
      if (irq_valid_o) begin
         if (active[2])      irq_id_o = 2'd2;
         else if (active[1]) irq_id_o = 2'd1;
         else                irq_id_o = 2'd0;
      end
   end

endmodule

// File: tb/tb_irq_request_unit.sv
// Scoreboard bench for irq_request_unit with DEBOUNCE_CYCLES=4; mask scenario runs only under IRQ_MASK_EN.
module tb_irq_request_unit;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst_i, ie_i, ack_valid_i;
   logic [2:0] btn_i;
   logic [1:0] ack_id_i;
   logic       irq_valid_o;
   logic [1:0] irq_id_o;
   logic [2:0] irw_o, overrun_o;
`ifdef IRQ_MASK_EN
   logic       mask_we_i;
   logic [2:0] mask_wdata_i;
`endif

   irq_request_unit #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .btn_i       (btn_i),
      .ie_i        (ie_i),
      .ack_valid_i (ack_valid_i),
      .ack_id_i    (ack_id_i),
`ifdef IRQ_MASK_EN
      .mask_we_i   (mask_we_i),
      .mask_wdata_i(mask_wdata_i),
`endif
      .irq_valid_o (irq_valid_o),
      .irq_id_o    (irq_id_o),
      .irw_o       (irw_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] irw;
      logic       vld;
      logic [1:0] id;
      logic [2:0] ovr;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] irw, input logic vld,
                             input logic [1:0] id, input logic [2:0] ovr);
      exp_t e;
      e.tag = tag; e.irw = irw; e.vld = vld; e.id = id; e.ovr = ovr;
      sb_q.push_back(e);
   endtask

   task automatic score();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, ".irw"},     32'(irw_o),       32'(e.irw));
         chk({e.tag, ".valid"},   32'(irq_valid_o), 32'(e.vld));
         chk({e.tag, ".id"},      32'(irq_id_o),    32'(e.id));
         chk({e.tag, ".overrun"}, 32'(overrun_o),   32'(e.ovr));
      end
   endtask

   task automatic ack(input logic [1:0] id);
      ack_valid_i = 1'b1;
      ack_id_i    = id;
      step(1);
      ack_valid_i = 1'b0;
      ack_id_i    = 2'd0;
   endtask

   initial begin
      rst_i = 1'b1; btn_i = 3'b000; ie_i = 1'b1; ack_valid_i = 1'b0; ack_id_i = 2'd0;
`ifdef IRQ_MASK_EN
      mask_we_i = 1'b0; mask_wdata_i = 3'b000;
`endif
      step(2);
      expect_out("reset", 3'b000, 1'b0, 2'd0, 3'b000); score();
      rst_i = 1'b0;
      step(1);

      // single press: accepted on edge DEB+2, not before
      btn_i = 3'b001;
      step(DEB + 1);
      expect_out("lat_early", 3'b000, 1'b0, 2'd0, 3'b000); score();
      step(1);
      expect_out("lat_exact", 3'b001, 1'b1, 2'd0, 3'b000); score();
      btn_i = 3'b000;
      step(DEB + 2);
      expect_out("release_keeps", 3'b001, 1'b1, 2'd0, 3'b000); score();
      ack(2'd0);
      expect_out("ack0", 3'b000, 1'b0, 2'd0, 3'b000); score();

      // glitch one cycle shorter than the debounce window
      btn_i = 3'b010;
      step(DEB - 1);
      btn_i = 3'b000;
      step(10);
      expect_out("glitch", 3'b000, 1'b0, 2'd0, 3'b000); score();

      // two sources, priority and sequential acks
      btn_i = 3'b101;
      step(DEB + 2);
      expect_out("prio", 3'b101, 1'b1, 2'd2, 3'b000); score();
      ack(2'd3);
      expect_out("ack3_ignored", 3'b101, 1'b1, 2'd2, 3'b000); score();
      ack(2'd1);
      expect_out("ack_nonpend", 3'b101, 1'b1, 2'd2, 3'b000); score();
      ack(2'd2);
      expect_out("ack2_next", 3'b001, 1'b1, 2'd0, 3'b000); score();
      ack(2'd0);
      expect_out("ack0_empty", 3'b000, 1'b0, 2'd0, 3'b000); score();
      btn_i = 3'b000;
      step(DEB + 2);

      // overrun on re-press while pending, then rise coinciding with ack
      btn_i = 3'b010; step(DEB + 2);
      expect_out("src1", 3'b010, 1'b1, 2'd1, 3'b000); score();
      btn_i = 3'b000; step(DEB + 2);
      btn_i = 3'b010; step(DEB + 2);
      expect_out("overrun", 3'b010, 1'b1, 2'd1, 3'b010); score();
      btn_i = 3'b000; step(DEB + 2);
      btn_i = 3'b010; step(DEB + 1);
      ack(2'd1);
      expect_out("rise_and_ack", 3'b010, 1'b1, 2'd1, 3'b000); score();
      ack(2'd1);
      expect_out("ack1", 3'b000, 1'b0, 2'd0, 3'b000); score();
      btn_i = 3'b000; step(DEB + 2);

      // ie gating and reset mid-debounce
      ie_i = 1'b0;
      btn_i = 3'b001; step(DEB + 2);
      expect_out("ie_off", 3'b001, 1'b0, 2'd0, 3'b000); score();
      ie_i = 1'b1; #1;
      expect_out("ie_on", 3'b001, 1'b1, 2'd0, 3'b000); score();
      btn_i = 3'b000; step(DEB + 2);
      btn_i = 3'b100; step(3);
      rst_i = 1'b1; step(1);
      expect_out("rst_mid", 3'b000, 1'b0, 2'd0, 3'b000); score();
      rst_i = 1'b0;
      step(DEB + 1);
      expect_out("post_rst_early", 3'b000, 1'b0, 2'd0, 3'b000); score();
      step(1);
      expect_out("post_rst_exact", 3'b100, 1'b1, 2'd2, 3'b000); score();

`ifdef IRQ_MASK_EN
      ack(2'd2);
      btn_i = 3'b000; step(DEB + 2);
      mask_we_i = 1'b1; mask_wdata_i = 3'b011; step(1);
      mask_we_i = 1'b0;
      btn_i = 3'b100; step(DEB + 2);
      expect_out("masked", 3'b100, 1'b0, 2'd0, 3'b000); score();
      mask_we_i = 1'b1; mask_wdata_i = 3'b111; step(1);
      mask_we_i = 1'b0;
      expect_out("unmasked", 3'b100, 1'b1, 2'd2, 3'b000); score();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_request_unit.md
IRQ_REQUEST_UNIT -- requirements
Module: irq_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100_000, min 2: cycles a synchronized button level must differ from its stable level before it is accepted.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn  input  3  raw asynchronous button levels; bit n = interrupt source n.
REQ-005 ie  input  1  global interrupt enable from the CPU.
REQ-006 ack_valid  input  1  CPU acknowledge strobe, one cycle.
REQ-007 ack_id  input  2  source being acknowledged (0..2); value 3 ignored.
REQ-008 irq_valid  output  1  request to CPU: at least one enabled, unmasked source pending.
REQ-009 irq_id  output  2  index of highest-priority pending, unmasked source; 0 when irq_valid=0.
REQ-010 irw  output  3  raw pending bits, for LEDs.
REQ-011 overrun  output  3  sticky per source: press accepted while already pending.

Function
REQ-012 Each btn bit SHALL pass a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Per source: counter resets to 0 whenever sync2 == stable; otherwise increments each edge; when it equals DEBOUNCE_CYCLES-1 with sync2 != stable, stable <= sync2 and counter <= 0.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change stable.
REQ-015 A rising stable transition (0->1) SHALL set pending[n] on the same edge stable updates; falling transitions set nothing.
REQ-016 Latency: a btn level change held steady SHALL make irw[n] visible after exactly DEBOUNCE_CYCLES+2 rising edges, counting the first edge that samples the new level.
REQ-017 Rising transition while pending[n]=1 SHALL set overrun[n]; pending stays 1.
REQ-018 ack_valid=1 with ack_id=n SHALL clear pending[n] and overrun[n] on that edge.
REQ-019 Ack of a non-pending source, or ack_id=3, SHALL change no state.
REQ-020 Rising transition and ack on the same source, same edge: pending[n] SHALL remain 1, overrun[n] SHALL clear.
REQ-021 Priority fixed: source 2 highest, source 0 lowest.
REQ-022 irq_valid = ie AND any(pending AND mask); irq_id is decoded combinationally from registers, zero added latency.
REQ-023 ie=0 SHALL NOT block pending/overrun capture; only irq_valid is gated.
REQ-024 Multiple sources pending: after ack of the highest, irq_id SHALL show the next highest in the following cycle.

Reset
REQ-025 rst=1 at an edge SHALL clear sync1, sync2, stable, counters, pending, overrun and mask-disabled state (mask <= 3'b111).
REQ-026 After reset: irq_valid=0, irq_id=0, irw=0, overrun=0.
REQ-027 Reset mid-debounce SHALL discard progress; a button held through reset is accepted DEBOUNCE_CYCLES+2 edges after rst deasserts.

Configuration
REQ-028 Macro IRQ_MASK_EN defined: extra ports mask_we (input 1) and mask_wdata (input 3); mask_we=1 loads mask <= mask_wdata at the edge; masked sources still capture pending but do not drive irq_valid/irq_id.
REQ-029 IRQ_MASK_EN undefined: ports absent, mask constant 3'b111, behaviour otherwise identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 rst, btn=3'b001 held, ie=1 -> irw=3'b001, irq_valid=1, irq_id=0 exactly 6 edges after first sampling edge, not earlier.
REQ-031 btn[1] pulsed high for 3 sync cycles then low -> irw stays 3'b000, irq_valid stays 0.
REQ-032 btn[0], btn[2] pending, ie=1 -> irq_id=2; ack_id=2 -> next cycle irq_id=0; ack_id=0 -> irq_valid=0.
REQ-033 pending[1]=1, btn[1] released and re-pressed (debounced) -> overrun=3'b010; same-edge ack_id=1 with new rise -> irw[1]=1, overrun[1]=0.
REQ-034 ie=0, btn[0] press -> irw=3'b001, irq_valid=0; ie=1 -> irq_valid=1 same cycle; rst asserted mid-debounce -> all outputs 0 next edge.
REQ-035 IRQ_MASK_EN: mask_wdata=3'b011 written, btn[2] pressed -> irw[2]=1, irq_valid=0; mask restored to 3'b111 -> irq_valid=1, irq_id=2.
